// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared state encodings and geometry helpers for the data-cache sequencer
//
// Purpose: FSM state constants and address-split width functions used by
//          dcache_ctrl and its sub-modules.
// Ports:   none (package).
package dcache_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOOKUP   = 3'd1;
  localparam logic [2:0] ST_FILL     = 3'd2;
  localparam logic [2:0] ST_WRITE    = 3'd3;
  localparam logic [2:0] ST_UNCACHED = 3'd4;
  localparam logic [2:0] ST_FLUSH    = 3'd5;

  // Byte-offset bits inside one word (a line is exactly one word).
  function automatic int offset_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int idx_bits(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_bits(input int addr_width, input int num_lines, input int data_width);
    return addr_width - idx_bits(num_lines) - offset_bits(data_width);
  endfunction

endpackage

// File: rtl/dcache_byte_merge.sv
// rtl/dcache_byte_merge.sv - combinational byte-enable merge of a store into an existing word
//
// Purpose: builds the updated cache word for a store hit.
// Ports:   old_word  in  DW    current SRAM contents
//          new_word  in  DW    store data
//          strb      in  DW/8  byte enables (1 = take new byte)
//          merged    out DW    resulting word
module dcache_byte_merge
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_word,
  input  logic [DATA_WIDTH-1:0]   new_word,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through data-cache sequencer
//
// Purpose: looks up CPU loads/stores in the external tag+data SRAM, refills
//          load misses from the memory bus, writes stores through (no
//          allocate), bypasses uncached accesses and runs whole-cache flushes.
// Optional: DCACHE_STATS_EN adds stat_hits/stat_misses counters.
// Ports:   clk, resetn (sync, active-low)
//          cpu_*    request in (valid/addr/wdata/wstrb/uncached), ready/rdata out
//          flush_req in, flush_busy out
//          mem_*    bus request out (valid/addr/wdata/wstrb), ready/rdata in
//          c_*      SRAM idx/tag/we/wdata/flush out, rdata/hit in (1-cycle read)
//          stat_*   hit/miss counters (DCACHE_STATS_EN only)
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = 512,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     cpu_valid,
  output logic                     cpu_ready,
  input  logic [ADDR_WIDTH-1:0]    cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  input  logic [DATA_WIDTH/8-1:0]  cpu_wstrb,
  input  logic                     cpu_uncached,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  input  logic                     flush_req,
  output logic                     flush_busy,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [DATA_WIDTH/8-1:0]  mem_wstrb,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic [idx_bits(NUM_LINES)-1:0]                          c_idx,
  output logic [tag_bits(ADDR_WIDTH, NUM_LINES, DATA_WIDTH)-1:0]  c_tag,
  output logic                     c_we,
  output logic [DATA_WIDTH-1:0]    c_wdata,
  output logic                     c_flush,
  input  logic [DATA_WIDTH-1:0]    c_rdata,
  input  logic                     c_hit
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]              stat_hits,
  output logic [31:0]              stat_misses
`endif
);

  localparam int OFF_W = offset_bits(DATA_WIDTH);
  localparam int IDX_W = idx_bits(NUM_LINES);
  localparam int TAG_W = tag_bits(ADDR_WIDTH, NUM_LINES, DATA_WIDTH);
  localparam int SW    = DATA_WIDTH / 8;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [SW-1:0]         req_wstrb;
  logic                  flush_pend;
  logic                  req_load;
  logic [DATA_WIDTH-1:0] merged;

  dcache_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .old_word (c_rdata),
    .new_word (req_wdata),
    .strb     (req_wstrb),
    .merged   (merged)
  );

  assign flush_busy = flush_pend;

  // In IDLE the SRAM is addressed straight from the CPU so its read data is
  // ready in LOOKUP; afterwards the latched request owns the SRAM port.
  always_comb begin
    req_load = (req_wstrb == '0);
    if (state == ST_IDLE) begin
      c_idx = cpu_addr[OFF_W +: IDX_W];
      c_tag = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
    end else begin
      c_idx = req_addr[OFF_W +: IDX_W];
      c_tag = req_addr[ADDR_WIDTH-1 -: TAG_W];
    end
    c_we    = ((state == ST_LOOKUP) && !req_load && c_hit) ||
              ((state == ST_FILL) && mem_valid && mem_ready);
    c_wdata = (state == ST_FILL) ? mem_rdata : merged;
    c_flush = (state == ST_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      cpu_ready  <= 1'b0;
      cpu_rdata  <= '0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      flush_pend <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_wstrb  <= '0;
    end else begin
      cpu_ready <= 1'b0;
      if (flush_req) flush_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (flush_pend || flush_req) begin
            state <= ST_FLUSH;
          // cpu_ready high means cpu_valid still belongs to the finished request.
          end else if (cpu_valid && !cpu_ready) begin
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
            req_wstrb <= cpu_wstrb;
            if (cpu_uncached) begin
              state     <= ST_UNCACHED;
              mem_valid <= 1'b1;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              mem_wstrb <= cpu_wstrb;
            end else begin
              state <= ST_LOOKUP;
            end
          end
        end
        ST_LOOKUP: begin
          if (req_load && c_hit) begin
            cpu_ready <= 1'b1;
            cpu_rdata <= c_rdata;
            state     <= ST_IDLE;
          end else if (req_load) begin
            state     <= ST_FILL;
            mem_valid <= 1'b1;
            mem_addr  <= {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            mem_wdata <= '0;
            mem_wstrb <= '0;
          end else begin
            state     <= ST_WRITE;
            mem_valid <= 1'b1;
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
            mem_wstrb <= req_wstrb;
          end
        end
        ST_FILL, ST_WRITE, ST_UNCACHED: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            cpu_ready <= 1'b1;
            if (state != ST_WRITE && req_load) cpu_rdata <= mem_rdata;
            state     <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          flush_pend <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state == ST_LOOKUP) begin
      if (c_hit) stat_hits <= stat_hits + 32'd1;
      else if (req_load) stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed self-checking bench for dcache_ctrl
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_valid;
  logic        cpu_ready;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_uncached;
  logic [31:0] cpu_rdata;
  logic        flush_req;
  logic        flush_busy;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic [8:0]  c_idx;
  logic [20:0] c_tag;
  logic        c_we;
  logic [31:0] c_wdata;
  logic        c_flush;
  logic [31:0] c_rdata;
  logic        c_hit;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk(clk), .resetn(resetn),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_uncached(cpu_uncached),
    .cpu_rdata(cpu_rdata), .flush_req(flush_req), .flush_busy(flush_busy),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .c_idx(c_idx), .c_tag(c_tag), .c_we(c_we), .c_wdata(c_wdata),
    .c_flush(c_flush), .c_rdata(c_rdata), .c_hit(c_hit)
  );

  // Cache SRAM: valid bits, tags and data, one-cycle registered read.
  logic        sram_v [512];
  logic [20:0] sram_t [512];
  logic [31:0] sram_d [512];

  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 512; i++) sram_v[i] <= 1'b0;
    end else if (c_flush) begin
      for (int i = 0; i < 512; i++) sram_v[i] <= 1'b0;
    end else if (c_we) begin
      sram_v[c_idx] <= 1'b1;
      sram_t[c_idx] <= c_tag;
      sram_d[c_idx] <= c_wdata;
    end
    c_rdata <= sram_d[c_idx];
    c_hit   <= resetn && sram_v[c_idx] && (sram_t[c_idx] == c_tag);
  end

  // Bus slave: answers mem_delay cycles after it first sees mem_valid.
  logic [31:0] mem_data;
  int          mem_delay;
  int          mem_wait;
  assign mem_rdata = mem_data;

  always @(posedge clk) begin
    if (!resetn || mem_ready) begin
      mem_ready <= 1'b0;
      mem_wait  <= 0;
    end else if (mem_valid) begin
      if (mem_wait == mem_delay) mem_ready <= 1'b1;
      else mem_wait <= mem_wait + 1;
    end
  end

  // Observations gathered each negedge.
  int          obs_cycles, obs_cwe, obs_flush, obs_clash, obs_unstable;
  logic [31:0] obs_cwdata, obs_rdata, obs_mem_addr, obs_mem_wdata;
  logic [3:0]  obs_mem_wstrb;
  logic        obs_mem_seen, obs_busy;
  logic        p_mv, p_mr;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_wstrb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (c_we) begin obs_cwe++; obs_cwdata = c_wdata; end
    if (c_flush) obs_flush++;
    if (c_we && c_flush) obs_clash++;
    if (mem_valid && !obs_mem_seen) begin
      obs_mem_seen  = 1'b1;
      obs_mem_addr  = mem_addr;
      obs_mem_wdata = mem_wdata;
      obs_mem_wstrb = mem_wstrb;
    end
    if (p_mv && !p_mr && (!mem_valid || mem_addr !== p_addr ||
        mem_wdata !== p_wdata || mem_wstrb !== p_wstrb)) obs_unstable++;
    p_mv = mem_valid; p_mr = mem_ready;
    p_addr = mem_addr; p_wdata = mem_wdata; p_wstrb = mem_wstrb;
  endtask

  task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic unc,
                        input logic [31:0] mdata, input int delay, input bit flush_mid);
    bit sent = 0;
    mem_data = mdata; mem_delay = delay;
    obs_cycles = 0; obs_cwe = 0; obs_flush = 0; obs_clash = 0; obs_unstable = 0;
    obs_mem_seen = 1'b0; obs_rdata = 'x; obs_busy = 1'b0;
    cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = wstrb; cpu_uncached = unc;
    cpu_valid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      tick();
      obs_cycles++;
      flush_req = 1'b0;
      if (cpu_ready) begin
        obs_rdata = cpu_rdata;
        obs_busy  = flush_busy;
        break;
      end
      if (flush_mid && mem_valid && !sent) begin flush_req = 1'b1; sent = 1; end
    end
    check("no_timeout", {31'd0, cpu_ready}, 32'd1);
    cpu_valid = 1'b0; cpu_wstrb = 4'h0; cpu_uncached = 1'b0; flush_req = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    cpu_uncached = 1'b0; flush_req = 1'b0; mem_data = '0; mem_delay = 0;
    p_mv = 1'b0; p_mr = 1'b0; p_addr = '0; p_wdata = '0; p_wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_c_we", {31'd0, c_we}, 32'd0);
    check("rst_c_flush", {31'd0, c_flush}, 32'd0);
    check("rst_flush_busy", {31'd0, flush_busy}, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    resetn = 1'b1;
    tick();

    // Cold load 0x100: fill from bus.
    access(32'h100, 0, 4'h0, 1'b0, 32'hDEADBEEF, 0, 0);
    check("cold_rdata", obs_rdata, 32'hDEADBEEF);
    check("cold_mem_addr", obs_mem_addr, 32'h100);
    check("cold_mem_wstrb", {28'd0, obs_mem_wstrb}, 32'd0);
    check("cold_c_we", obs_cwe, 32'd1);
    check("cold_c_wdata", obs_cwdata, 32'hDEADBEEF);
    check("cold_latency", obs_cycles, 32'd4);
    tick();

    // Repeat load: hit in 2 cycles, no bus traffic.
    access(32'h100, 0, 4'h0, 1'b0, 32'h0BADF00D, 0, 0);
    check("hit_rdata", obs_rdata, 32'hDEADBEEF);
    check("hit_latency", obs_cycles, 32'd2);
    check("hit_no_mem", {31'd0, obs_mem_seen}, 32'd0);
    tick();

    // Store hit with partial strobes: merge into SRAM and write through.
    access(32'h100, 32'h0000_1234, 4'b0011, 1'b0, 32'h0, 0, 0);
    check("st_c_wdata", obs_cwdata, 32'hDEAD1234);
    check("st_c_we", obs_cwe, 32'd1);
    check("st_mem_wstrb", {28'd0, obs_mem_wstrb}, 32'd3);
    check("st_mem_addr", obs_mem_addr, 32'h100);
    check("st_mem_wdata", obs_mem_wdata, 32'h0000_1234);
    tick();

    access(32'h100, 0, 4'h0, 1'b0, 32'h0, 0, 0);
    check("st_readback", obs_rdata, 32'hDEAD1234);
    check("st_readback_lat", obs_cycles, 32'd2);
    tick();

    // Conflicting tag in the same line evicts 0x100.
    access(32'h900, 0, 4'h0, 1'b0, 32'hCAFEF00D, 0, 0);
    check("conf_rdata", obs_rdata, 32'hCAFEF00D);
    check("conf_mem_addr", obs_mem_addr, 32'h900);
    check("conf_miss", {31'd0, obs_mem_seen}, 32'd1);
    tick();
    access(32'h100, 0, 4'h0, 1'b0, 32'h11112222, 0, 0);
    check("evict_miss", {31'd0, obs_mem_seen}, 32'd1);
    check("evict_rdata", obs_rdata, 32'h11112222);
    tick();

    // Flush raised during a fill: fill finishes first, then one flush pulse.
    access(32'h900, 0, 4'h0, 1'b0, 32'h33334444, 0, 1);
    check("fl_rdata", obs_rdata, 32'h33334444);
    check("fl_busy_at_ready", {31'd0, obs_busy}, 32'd1);
    check("fl_no_early_flush", obs_flush, 32'd0);
    repeat (4) tick();
    check("fl_one_pulse", obs_flush, 32'd1);
    check("fl_no_clash", obs_clash, 32'd0);
    check("fl_busy_clear", {31'd0, flush_busy}, 32'd0);
    access(32'h900, 0, 4'h0, 1'b0, 32'h55556666, 0, 0);
    check("post_flush_miss", {31'd0, obs_mem_seen}, 32'd1);
    check("post_flush_rdata", obs_rdata, 32'h55556666);
    tick();

    // Uncached load with a slow bus.
    access(32'h1000_0000, 0, 4'h0, 1'b1, 32'h55AA55AA, 5, 0);
    check("unc_rdata", obs_rdata, 32'h55AA55AA);
    check("unc_mem_addr", obs_mem_addr, 32'h1000_0000);
    check("unc_no_c_we", obs_cwe, 32'd0);
    check("unc_stable", obs_unstable, 32'd0);
    check("unc_latency", obs_cycles, 32'd8);
    tick();

    // Store miss: written through, not allocated.
    access(32'h500, 32'hA5A5A5A5, 4'hF, 1'b0, 32'h0, 2, 0);
    check("stm_no_c_we", obs_cwe, 32'd0);
    check("stm_mem_wstrb", {28'd0, obs_mem_wstrb}, 32'hF);
    check("stm_stable", obs_unstable, 32'd0);
    tick();
    access(32'h500, 0, 4'h0, 1'b0, 32'h77778888, 0, 0);
    check("stm_not_alloc", {31'd0, obs_mem_seen}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
